// File: rtl/page_serializer.sv
// Ping-pong page buffer that streams one N_WORDS page out one word per accepted cycle.
// Optional macro SERDES_LEAD_IN_EN emits LEAD_IN_WORDS zero words after every reset.
module page_serializer #(
   parameter int N_WORDS       = 16,
   parameter int WIDTH         = 32,
   parameter int LEAD_IN_WORDS = 11,
   parameter int CNT_W         = 13
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_WORDS*WIDTH-1:0] din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_first,
   output logic                     dout_last,
   output logic [CNT_W-1:0]         page_cnt
);

   localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int PW    = N_WORDS * WIDTH;

   if (LEAD_IN_WORDS < 1 || LEAD_IN_WORDS > 15) begin : g_lead_range
      $error("page_serializer: LEAD_IN_WORDS must be 1..15");
   end
   if (N_WORDS < 2 || N_WORDS > 32 || (N_WORDS & (N_WORDS - 1)) != 0) begin : g_words_range
      $error("page_serializer: N_WORDS must be a power of two in 2..32");
   end

   logic [PW-1:0]      slot_q [2];
   logic               wsel_q, wsel_d;
   logic               rsel_q, rsel_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         occ_q, occ_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               lead_active;
   logic               page_valid;
   logic               load;
   logic               page_xfer;
   logic               last_xfer;
   logic [PW-1:0]      rd_page;
   logic [WIDTH-1:0]   words [N_WORDS];

`ifdef SERDES_LEAD_IN_EN
   logic [3:0] lead_q;

   assign lead_active = (lead_q != 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lead_q <= 4'(LEAD_IN_WORDS);
      end else if (lead_active && dout_ready) begin
         lead_q <= lead_q - 4'd1;
      end
   end
`else
   assign lead_active = 1'b0;
`endif

   // occupancy==2 means both slots hold pages; the drained slot is never the write target
   assign din_ready  = (occ_q != 2'd2);
   assign load       = din_valid && din_ready;
   assign page_valid = !lead_active && (occ_q != 2'd0);
   assign page_xfer  = page_valid && dout_ready;
   assign last_xfer  = page_xfer && (idx_q == IDX_W'(N_WORDS - 1));

   always_comb begin
      wsel_d = wsel_q ^ load;
      rsel_d = rsel_q ^ last_xfer;
      occ_d  = occ_q + 2'(load) - 2'(last_xfer);
      cnt_d  = cnt_q + CNT_W'(last_xfer);
      idx_d  = idx_q;
      if (last_xfer) begin
         idx_d = '0;
      end else if (page_xfer) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wsel_q <= 1'b0;
         rsel_q <= 1'b0;
         idx_q  <= '0;
         occ_q  <= 2'd0;
         cnt_q  <= '0;
      end else begin
         wsel_q <= wsel_d;
         rsel_q <= rsel_d;
         idx_q  <= idx_d;
         occ_q  <= occ_d;
         cnt_q  <= cnt_d;
      end
   end

   // Page storage needs no reset: outputs are masked by occupancy
   always_ff @(posedge clk) begin
      if (load) begin
         slot_q[wsel_q] <= din;
      end
   end

   assign rd_page = rsel_q ? slot_q[1] : slot_q[0];

   for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
      assign words[gi] = rd_page[gi*WIDTH +: WIDTH];
   end

   assign dout_valid = lead_active || page_valid;
   assign dout       = page_valid ? words[idx_q] : '0;
   assign dout_first = page_valid && (idx_q == '0);
   assign dout_last  = page_valid && (idx_q == IDX_W'(N_WORDS - 1));
   assign page_cnt   = cnt_q;

endmodule

// File: tb/tb_page_serializer.sv
// Self-checking bench for page_serializer: directed table, corner sequences and a
// randomized run scored against a word-queue reference model.
module tb_page_serializer;

   localparam int N    = 16;
   localparam int W    = 32;
   localparam int LEAD = 11;
   localparam int CW   = 6;
   localparam int PW   = N * W;
`ifdef SERDES_LEAD_IN_EN
   localparam int LEAD_EXP = LEAD;
`else
   localparam int LEAD_EXP = 0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [PW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          dout_first;
   logic          dout_last;
   logic [CW-1:0] page_cnt;

   page_serializer #(
      .N_WORDS(N), .WIDTH(W), .LEAD_IN_WORDS(LEAD), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_first(dout_first), .dout_last(dout_last),
      .page_cnt(page_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: flat queue of every word still owed to the receiver
   typedef struct {
      logic [W-1:0] w;
      bit           first;
      bit           last;
   } word_t;

   word_t exp_q[$];
   int    pending;
   int    done_pages;
   int    n_checks;
   int    n_errors;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk_page(input logic [W-1:0] base);
      logic [PW-1:0] p;
      for (int k = 0; k < N; k++) p[k*W +: W] = base + W'(k);
      return p;
   endfunction

   function automatic logic [PW-1:0] rnd_page();
      logic [PW-1:0] p;
      for (int k = 0; k < N; k++) p[k*W +: W] = $urandom;
      return p;
   endfunction

   task automatic check_outputs();
      bit v;
      v = (exp_q.size() > 0);
      chk("dout_valid", W'(dout_valid), W'(v));
      if (v) begin
         chk("dout", dout, exp_q[0].w);
         chk("dout_first", W'(dout_first), W'(exp_q[0].first));
         chk("dout_last", W'(dout_last), W'(exp_q[0].last));
      end else begin
         chk("dout_idle", dout, '0);
         chk("first_last_idle", W'({dout_first, dout_last}), '0);
      end
      chk("din_ready", W'(din_ready), W'(pending < 2));
      chk("page_cnt", W'(page_cnt), W'(done_pages % (1 << CW)));
   endtask

   // Called at posedge+1: drive, check, advance the model across the next edge
   task automatic step(input logic dv, input logic [PW-1:0] d, input logic rdy);
      bit    accept;
      word_t e;
      din_valid  = dv;
      din        = d;
      dout_ready = rdy;
      check_outputs();
      accept = dv && (pending < 2);
      if (exp_q.size() > 0 && rdy) begin
         e = exp_q.pop_front();
         if (e.last) begin
            pending--;
            done_pages++;
         end
      end
      if (accept) begin
         for (int k = 0; k < N; k++) begin
            e.w = d[k*W +: W];
            e.first = (k == 0);
            e.last = (k == N - 1);
            exp_q.push_back(e);
         end
         pending++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      word_t e;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_dout_valid", W'(dout_valid), '0);
      chk("rst_dout", dout, '0);
      chk("rst_first_last", W'({dout_first, dout_last}), '0);
      chk("rst_page_cnt", W'(page_cnt), '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      pending = 0;
      done_pages = 0;
      for (int k = 0; k < LEAD_EXP; k++) begin
         e.w = '0;
         e.first = 1'b0;
         e.last = 1'b0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("rst_din_ready", W'(din_ready), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         step(1'b0, '0, 1'b1);
         n++;
      end
      chk("drain_timeout", exp_q.size(), '0);
   endtask

   typedef struct {
      logic [W-1:0] base;
      int           toggle;
      int           exp_cycles;
   } vec_t;

   vec_t          vecs[4];
   logic [PW-1:0] pg[3];
   logic [CW-1:0] pc0;
   logic [CW-1:0] pdelta;
   int            cyc, s, nxt, c_step, a_last, first_v, last_v, nvalid, nlead;

   initial begin
      n_checks = 0;
      n_errors = 0;
      vecs[0] = '{base: 32'h0000_1000, toggle: 0, exp_cycles: 16};
      vecs[1] = '{base: 32'h0000_2000, toggle: 1, exp_cycles: 32};
      vecs[2] = '{base: 32'hA5A5_0000, toggle: 0, exp_cycles: 16};
      vecs[3] = '{base: 32'hFFFF_FFF8, toggle: 1, exp_cycles: 32};

      @(posedge clk);
      #1;
      apply_reset();
      drain();

      // Single pages, continuous or alternating dout_ready
      for (int i = 0; i < 4; i++) begin
         pc0 = page_cnt;
         step(1'b1, mk_page(vecs[i].base), 1'b0);
         cyc = 0;
         while (dout_valid && cyc < 200) begin
            step(1'b0, '0, (vecs[i].toggle == 0) ? 1'b1 : 1'(cyc % 2));
            cyc++;
         end
         pdelta = page_cnt - pc0;
         chk("tbl_cycles", cyc, vecs[i].exp_cycles);
         chk("tbl_pcnt_delta", W'(pdelta), 32'd1);
         $display("vector %0d: base=0x%0h toggle=%0d cycles=%0d", i, vecs[i].base, vecs[i].toggle, cyc);
      end

      // Three pages back-to-back: no bubbles, third load accepted right after A's last word
      pg[0] = mk_page(32'h0000_A000);
      pg[1] = mk_page(32'h0000_B000);
      pg[2] = mk_page(32'h0000_C000);
      pc0 = page_cnt;
      nxt = 0; s = 0; c_step = -1; a_last = -1; first_v = -1; last_v = -1; nvalid = 0;
      while (s < 100 && (nxt < 3 || dout_valid)) begin
         if (dout_valid) begin
            if (first_v < 0) first_v = s;
            last_v = s;
            nvalid++;
            if (dout_last && dout == 32'h0000_A00F) a_last = s;
         end
         if (nxt == 2 && din_ready && c_step < 0) c_step = s;
         if (nxt < 3) begin
            if (din_ready) begin
               step(1'b1, pg[nxt], 1'b1);
               nxt++;
            end else begin
               step(1'b1, pg[nxt], 1'b1);
            end
         end else begin
            step(1'b0, '0, 1'b1);
         end
         s++;
      end
      pdelta = page_cnt - pc0;
      chk("b2b_valid_words", nvalid, 32'd48);
      chk("b2b_no_bubbles", last_v - first_v + 1, 32'd48);
      chk("b2b_third_accept", c_step, a_last + 1);
      chk("b2b_pcnt_delta", W'(pdelta), 32'd3);
      $display("back-to-back: words=%0d span=%0d third_accept=%0d", nvalid, last_v - first_v + 1, c_step);

      // Load lands on the same edge as the last word of the draining page
      step(1'b1, mk_page(32'h0000_D000), 1'b1);
      s = 0;
      while (!(dout_valid && dout_last) && s < 40) begin
         step(1'b0, '0, 1'b1);
         s++;
      end
      chk("same_edge_ready", W'(din_ready), 32'd1);
      step(1'b1, mk_page(32'h0000_E000), 1'b1);
      chk("same_edge_word0", dout, 32'h0000_E000);
      chk("same_edge_first", W'(dout_first), 32'd1);
      chk("same_edge_occ1", W'(din_ready), 32'd1);
      drain();
      $display("same-edge load: next page word0=0x%0h", dout);

      // Counter wrap: stream to 2^CW-1 pages, then one more
      s = 0;
      while (done_pages + pending < (1 << CW) - 1 && s < 3000) begin
         step(1'b1, rnd_page(), 1'b1);
         s++;
      end
      drain();
      chk("wrap_before", W'(page_cnt), W'((1 << CW) - 1));
      step(1'b1, rnd_page(), 1'b1);
      drain();
      chk("wrap_after", W'(page_cnt), '0);
      $display("page_cnt wrap: pages=%0d page_cnt=%0d", done_pages, page_cnt);

      // Reset in the middle of a page
      step(1'b1, mk_page(32'h0000_7000), 1'b1);
      s = 0;
      while (dout !== 32'h0000_7007 && s < 40) begin
         step(1'b0, '0, 1'b1);
         s++;
      end
      apply_reset();
      step(1'b1, mk_page(32'h0000_8000), 1'b1);
      nlead = 1;
      while (!dout_first && nlead < 40) begin
         step(1'b0, '0, 1'b1);
         nlead++;
      end
      chk("post_reset_lead", nlead, (LEAD_EXP == 0) ? 32'd1 : W'(LEAD_EXP));
      chk("post_reset_word0", dout, 32'h0000_8000);
      chk("post_reset_pcnt", W'(page_cnt), '0);
      drain();
      $display("mid-page reset: cycles to word0=%0d", nlead);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), rnd_page(), 1'($urandom_range(0, 3) != 0));
      end
      drain();
      $display("random run: pages=%0d", done_pages);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
